// File: rtl/unit_run_ctrl_pkg.sv
// Shared types and constants for the unit run/fault sequencer.
// State encoding, fault bit positions and first-fault codes.
package unit_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_RDY = 3'd0,
    ST_READY    = 3'd1,
    ST_PRECHG   = 3'd2,
    ST_MAIN_ON  = 3'd3,
    ST_RUN      = 3'd4,
    ST_STOPPING = 3'd5,
    ST_FAULT    = 3'd6
  } state_t;

  typedef enum int {
    F_FAULT1 = 0,
    F_FAULT2 = 1,
    F_FAULT3 = 2,
    F_FAULT4 = 3,
    F_OV     = 4,
    F_UV     = 5,
    F_TEM    = 6,
    F_CALL   = 7
  } fault_bit_e;

  localparam int FAULT_W       = 8;
  localparam int MASK_W        = 9;
  localparam int PRECHG_TO_BIT = 8;

  localparam logic [3:0] FF_NONE      = 4'd0;
  localparam logic [3:0] FF_PRECHG_TO = 4'd9;

  // Lowest set bit wins; code is bit index + 1.
  function automatic logic [3:0] first_code(
    input logic [FAULT_W-1:0] f
  );
    logic [3:0] c;
    c = FF_NONE;
    for (int i = int'(F_CALL); i >= int'(F_FAULT1); i--) begin
      if (f[i]) c = 4'(i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/unit_run_ctrl_fault_latch.sv
// Sticky fault mask and first-fault code capture.
// Clear has priority over capture.
module unit_run_ctrl_fault_latch
  import unit_run_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [FAULT_W-1:0] faults,
  input  logic               tmo,
  input  logic               clr,
  input  logic               en,
  output logic [MASK_W-1:0]  fault_mask,
  output logic [3:0]         fault_first
);

  logic [MASK_W-1:0] hit;
  logic [3:0]        code;

  always_comb begin
    hit = MASK_W'(faults);
    hit[PRECHG_TO_BIT] = tmo;
    code = first_code(faults);
    if (code == FF_NONE && tmo) code = FF_PRECHG_TO;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fault_mask  <= '0;
      fault_first <= FF_NONE;
    end else if (clr) begin
      fault_mask  <= '0;
      fault_first <= FF_NONE;
    end else if (en) begin
      fault_mask <= fault_mask | hit;
      if (fault_first == FF_NONE) fault_first <= code;
    end
  end

endmodule

// File: rtl/unit_run_ctrl.sv
// Run/fault sequencer: precharge, main contactor, PWM enable.
// Outputs are registered from the next-state decode.
module unit_run_ctrl
  import unit_run_ctrl_pkg::*;
#(
  parameter int PRECHG_MIN = 50,
  parameter int PRECHG_TMO = 3000,
  parameter int MAIN_DLY   = 25,
  parameter int STOP_DLY   = 25,
  parameter int CNT_W      = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tick,
  input  logic               sysrdy,
  input  logic [FAULT_W-1:0] faults,
  input  logic               dc_ok,
  input  logic               start,
  input  logic               stop,
  input  logic               fault_rst,
  output logic               prechg_relay,
  output logic               main_relay,
  output logic               pwm_en,
  output logic               running,
  output logic               fault_active,
  output logic [3:0]         fault_first,
  output logic [MASK_W-1:0]  fault_mask,
  output logic [2:0]         state
);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(PRECHG_MIN);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(PRECHG_TMO);
  localparam logic [CNT_W-1:0] MAIN_C = CNT_W'(MAIN_DLY);
  localparam logic [CNT_W-1:0] STOP_C = CNT_W'(STOP_DLY);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(2);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tmo;
  logic             any_fault;
  logic             clr;
  logic             cap_en;

  assign any_fault = |faults;
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    tmo     = 1'b0;
    if (state_q != ST_WAIT_RDY && any_fault) begin
      state_d = ST_FAULT;
    end else if (state_q != ST_FAULT && !sysrdy) begin
      state_d = ST_WAIT_RDY;
    end else begin
      case (state_q)
        ST_WAIT_RDY: state_d = ST_READY;
        ST_READY: begin
          if (start && !stop) state_d = ST_PRECHG;
        end
        ST_PRECHG: begin
          if (stop) begin
            state_d = ST_STOPPING;
          end else if (cnt_q >= MIN_C && dc_ok) begin
            state_d = ST_MAIN_ON;
          end else if (cnt_q >= TMO_C) begin
            state_d = ST_FAULT;
            tmo     = 1'b1;
          end
        end
        ST_MAIN_ON: begin
          if (stop) state_d = ST_STOPPING;
          else if (cnt_q >= MAIN_C) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (stop) state_d = ST_STOPPING;
        end
        ST_STOPPING: begin
          if (cnt_q >= STOP_C) state_d = ST_READY;
        end
        ST_FAULT: begin
          if (fault_rst) begin
            state_d = sysrdy ? ST_READY : ST_WAIT_RDY;
          end
        end
        default: state_d = ST_WAIT_RDY;
      endcase
    end
  end

  // Counter restarts on every state change and saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (tick && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign clr    = (state_q == ST_FAULT) && (state_d != ST_FAULT);
  assign cap_en = (state_q != ST_WAIT_RDY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_WAIT_RDY;
      cnt_q        <= '0;
      prechg_relay <= 1'b0;
      main_relay   <= 1'b0;
      pwm_en       <= 1'b0;
      running      <= 1'b0;
      fault_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prechg_relay <= (state_d == ST_PRECHG) ||
                      (state_d == ST_MAIN_ON && cnt_d < HOLD_C);
      main_relay   <= (state_d == ST_MAIN_ON) ||
                      (state_d == ST_RUN) ||
                      (state_d == ST_STOPPING);
      pwm_en       <= (state_d == ST_RUN);
      running      <= (state_d == ST_RUN);
      fault_active <= (state_d == ST_FAULT);
    end
  end

  unit_run_ctrl_fault_latch u_latch (
    .clk         (clk),
    .rstn        (rstn),
    .faults      (faults),
    .tmo         (tmo),
    .clr         (clr),
    .en          (cap_en),
    .fault_mask  (fault_mask),
    .fault_first (fault_first)
  );

endmodule

// File: doc/unit_run_ctrl.md
Name: unit_run_ctrl

Overview:
- Run/fault sequencer for one power unit.
- After the init block asserts sysrdy, it sequences the precharge relay, the main contactor and the PWM enable in response to start/stop commands.
- It latches unit faults (first-fault code plus an accumulated mask) and holds the unit safe until an operator fault reset.
- It sits between the init/LED block and the PWM/gate-drive datapath.

Parameters:
- PRECHG_MIN, 50: minimum ticks the precharge relay is held before dc_ok is accepted.
- PRECHG_TMO, 3000: ticks without dc_ok before a precharge-timeout fault (must exceed PRECHG_MIN).
- MAIN_DLY, 25: ticks from main contactor close to PWM enable.
- STOP_DLY, 25: ticks from PWM disable to contactor open.
- CNT_W, 12: tick counter width; must hold PRECHG_TMO.

Ports:
- clk, in, 1: system clock.
- rstn, in, 1: reset, asynchronous, active-low.
- tick, in, 1: one-clk timebase pulse (200 us period in system).
- sysrdy, in, 1: init complete; level.
- faults, in, 8: {fault1,fault2,fault3,fault4,ov,uv,tem,call}; bit0 = fault1; level, active-high.
- dc_ok, in, 1: DC-link voltage above precharge threshold.
- start, in, 1: run command, one-clk pulse.
- stop, in, 1: stop command, one-clk pulse.
- fault_rst, in, 1: fault reset request, one-clk pulse.
- prechg_relay, out, 1: precharge relay drive.
- main_relay, out, 1: main contactor drive.
- pwm_en, out, 1: PWM datapath enable.
- running, out, 1: high in RUN state only.
- fault_active, out, 1: high in FAULT state.
- fault_first, out, 4: index+1 of the first fault latched; 0 = none; 9 = precharge timeout.
- fault_mask, out, 9: sticky OR of all faults since last reset; bit8 = precharge timeout.
- state, out, 3: current state encoding, for debug.

Behaviour:
- Reset: state WAIT_RDY. All outputs 0; counter 0; fault_first 0; fault_mask 0.
- All outputs are registered and are functions of the registered state and latches.
- States: WAIT_RDY=0, READY=1, PRECHG=2, MAIN_ON=3, RUN=4, STOPPING=5, FAULT=6.
- WAIT_RDY -> READY when sysrdy=1. If sysrdy falls in any non-FAULT state, go to WAIT_RDY and drop all relays and PWM. No fault is logged for this.
- READY -> PRECHG on start.
  - In PRECHG: prechg_relay=1 and the counter counts ticks.
  - When count >= PRECHG_MIN and dc_ok=1, go to MAIN_ON with counter cleared.
  - When count reaches PRECHG_TMO, go to FAULT with the precharge-timeout fault.
- MAIN_ON: main_relay=1, and prechg_relay=1 until the counter reaches 2. After MAIN_DLY ticks, go to RUN.
- RUN: main_relay=1, pwm_en=1, running=1. On stop, go to STOPPING.
- STOPPING: pwm_en=0, main_relay=1. After STOP_DLY ticks, go to READY with main_relay=0.
- stop in PRECHG or MAIN_ON: go directly to STOPPING.
- start outside READY is ignored. start and stop in the same cycle: stop wins.
- Faults:
  - Any faults bit high in any state other than WAIT_RDY moves the state to FAULT on the next clk.
  - In that same next clk, pwm_en, main_relay and prechg_relay all go to 0. Trip latency is 1 clk.
- Fault latching:
  - fault_mask |= faults every clk while not in WAIT_RDY.
  - fault_first is loaded only while it is 0. The lowest set bit wins on simultaneous faults: value = bit index + 1.
  - The precharge-timeout fault sets mask bit8 and fault_first=9 if fault_first was 0.
- FAULT exit:
  - Occurs on fault_rst when faults==0, going to READY (or to WAIT_RDY if sysrdy=0).
  - On exit, fault_mask and fault_first clear.
  - fault_rst while any faults bit is still high is ignored; the state stays FAULT.
- Counter: counts only on tick, clears on every state transition, and saturates at all-ones.
- No relay output is ever 1 in WAIT_RDY, READY or FAULT.

Decomposition:
- Shared package: the state encoding constants, fault bit indices, the PRECHG_TO_BIT=8 constant, and the fault_first code values.
- One natural sub-module: fault_latch. It takes the faults vector, the timeout flag, a clear input and a capture enable, and produces fault_mask and fault_first.
- The FSM and the tick counter stay in the top level.

Test Plan (bench uses PRECHG_MIN=4, PRECHG_TMO=20, MAIN_DLY=3, STOP_DLY=5, tick every 4 clk):
- Normal start: set sysrdy=1, pulse start, raise dc_ok after 2 ticks.
  - prechg_relay rises 1 clk after start.
  - State reaches MAIN_ON at tick 4.
  - pwm_en and running rise 3 ticks later.
- Stop: pulse stop in RUN.
  - pwm_en drops next clk.
  - main_relay drops 5 ticks later.
  - State returns to READY=1.
- Precharge timeout: start with dc_ok held 0.
  - FAULT at tick 20, prechg_relay=0.
  - fault_first=9, fault_mask=9'h100.
- Run trip: raise faults=8'h30 (ov, uv) in RUN.
  - Next clk: pwm_en=0, main_relay=0, fault_first=5, fault_mask=9'h030.
- Reset rules: pulse fault_rst while faults=8'h10; state stays FAULT. Clear faults and pulse fault_rst again: READY, mask 0, first 0.
- Mid-operation reset: assert rstn=0 while in RUN; all outputs 0 immediately (asynchronous), state=0.
